// File: rtl/bnn_pkg.sv
// Shared types and helpers for the BNN vote accumulator slice.
package bnn_pkg;

    localparam int NUM_NEURONS_DEF = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int WINDOW_DEF      = 16;

    typedef enum logic {
        ACCUM  = 1'b0,
        DECIDE = 1'b1
    } bnn_state_e;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        logic [31:0] result;
        result = (value >= max_value) ? value : value + 32'd1;
        return result;
    endfunction

endpackage

// File: rtl/bnn_vote_accumulator_if.sv
// Sample-in / decision-out bundle of the BNN vote accumulator.
interface bnn_vote_accumulator_if #(
    parameter int NUM_NEURONS = 4,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 2
) ();
    logic                   in_valid;
    logic [NUM_NEURONS-1:0] neuron_bits;
    logic                   in_ready;
    logic                   out_valid;
    logic [IDX_W-1:0]       class_idx;
    logic [CNT_W-1:0]       class_count;
    logic                   tie;
    logic                   busy;

    modport master (
        output in_valid, neuron_bits,
        input  in_ready, out_valid, class_idx, class_count, tie, busy
    );

    modport slave (
        input  in_valid, neuron_bits,
        output in_ready, out_valid, class_idx, class_count, tie, busy
    );
endinterface

// File: rtl/bnn_argmax_scan.sv
// Sequential argmax over the vote counters, one neuron per enabled edge;
// lowest index wins, tie flags any later neuron matching the final maximum.
module bnn_argmax_scan
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] counts [NUM_NEURONS],
    output logic             done,
    output logic [IDX_W-1:0] best_idx,
    output logic [CNT_W-1:0] best_cnt,
    output logic             tie
);

    logic [IDX_W-1:0] scan_idx_reg;
    logic [IDX_W-1:0] best_idx_reg;
    logic [CNT_W-1:0] best_cnt_reg;
    logic             tie_reg;
    logic             active_reg;
    logic             done_reg;
    logic [CNT_W-1:0] cur_cnt;
    logic             last_idx;

    assign cur_cnt  = counts[scan_idx_reg];
    assign last_idx = (scan_idx_reg == IDX_W'(NUM_NEURONS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_reg <= '0;
            best_idx_reg <= '0;
            best_cnt_reg <= '0;
            tie_reg      <= 1'b0;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else if (clear) begin
            scan_idx_reg <= '0;
            best_idx_reg <= '0;
            best_cnt_reg <= '0;
            tie_reg      <= 1'b0;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else if (ena) begin
            if (start) begin
                scan_idx_reg <= '0;
                best_idx_reg <= '0;
                best_cnt_reg <= '0;
                tie_reg      <= 1'b0;
                active_reg   <= 1'b1;
                done_reg     <= 1'b0;
            end else if (done_reg) begin
                // The accumulator publishes on this same edge.
                active_reg   <= 1'b0;
                done_reg     <= 1'b0;
                scan_idx_reg <= '0;
            end else if (active_reg) begin
                if (cur_cnt > best_cnt_reg) begin
                    best_idx_reg <= scan_idx_reg;
                    best_cnt_reg <= cur_cnt;
                    tie_reg      <= 1'b0;
                end else if (cur_cnt == best_cnt_reg && scan_idx_reg != '0) begin
                    tie_reg      <= 1'b1;
                end
                if (last_idx) begin
                    done_reg     <= 1'b1;
                end else begin
                    scan_idx_reg <= scan_idx_reg + 1'b1;
                end
            end
        end
    end

    assign done     = done_reg;
    assign best_idx = best_idx_reg;
    assign best_cnt = best_cnt_reg;
    assign tie      = tie_reg;

endmodule

// File: rtl/bnn_vote_accumulator.sv
// Per-neuron vote counting over a WINDOW of samples, then argmax publish.
// Optional BNN_DROP_COUNT_EN adds a saturating count of samples dropped while busy.
module bnn_vote_accumulator
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WINDOW      = WINDOW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               clear,
    bnn_vote_accumulator_if.slave bus
`ifdef BNN_DROP_COUNT_EN
    ,
    output logic [CNT_W-1:0]   drop_count
`endif
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    bnn_state_e       state_reg;
    logic [CNT_W-1:0] sample_cnt_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [IDX_W-1:0] class_idx_reg;
    logic [CNT_W-1:0] class_count_reg;
    logic             tie_reg;
    logic             busy_reg;

    logic [CNT_W-1:0] vote_cnt [NUM_NEURONS];
    logic             accept;
    logic             final_sample;
    logic             publish;
    logic             scan_done;
    logic [IDX_W-1:0] scan_best_idx;
    logic [CNT_W-1:0] scan_best_cnt;
    logic             scan_tie;

    assign accept       = ena && bus.in_valid && (state_reg == ACCUM);
    assign final_sample = (sample_cnt_reg == CNT_W'(WINDOW - 1));
    assign publish      = ena && (state_reg == DECIDE) && scan_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : gen_vote
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (clear || publish) begin
                    cnt_reg <= '0;
                end else if (accept && bus.neuron_bits[gi]) begin
                    cnt_reg <= CNT_W'(sat_inc(32'(cnt_reg), CNT_MAX));
                end
            end

            assign vote_cnt[gi] = cnt_reg;
        end
    endgenerate

    bnn_argmax_scan #(
        .NUM_NEURONS (NUM_NEURONS),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .clear    (clear),
        .start    (accept && final_sample),
        .counts   (vote_cnt),
        .done     (scan_done),
        .best_idx (scan_best_idx),
        .best_cnt (scan_best_cnt),
        .tie      (scan_tie)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ACCUM;
            sample_cnt_reg  <= '0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            class_idx_reg   <= '0;
            class_count_reg <= '0;
            tie_reg         <= 1'b0;
            busy_reg        <= 1'b0;
        end else if (clear) begin
            state_reg       <= ACCUM;
            sample_cnt_reg  <= '0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            class_idx_reg   <= '0;
            class_count_reg <= '0;
            tie_reg         <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (ena) begin
                case (state_reg)
                    ACCUM: begin
                        if (accept) begin
                            sample_cnt_reg <= CNT_W'(sat_inc(32'(sample_cnt_reg), CNT_MAX));
                            if (final_sample) begin
                                state_reg    <= DECIDE;
                                in_ready_reg <= 1'b0;
                                busy_reg     <= 1'b1;
                            end
                        end
                    end
                    DECIDE: begin
                        if (publish) begin
                            state_reg       <= ACCUM;
                            sample_cnt_reg  <= '0;
                            in_ready_reg    <= 1'b1;
                            busy_reg        <= 1'b0;
                            out_valid_reg   <= 1'b1;
                            class_idx_reg   <= scan_best_idx;
                            class_count_reg <= scan_best_cnt;
                            tie_reg         <= scan_tie;
                        end
                    end
                    default: state_reg <= ACCUM;
                endcase
            end
        end
    end

`ifdef BNN_DROP_COUNT_EN
    logic [CNT_W-1:0] drop_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_reg <= '0;
        end else if (clear) begin
            drop_count_reg <= '0;
        end else if (ena && bus.in_valid && !in_ready_reg) begin
            drop_count_reg <= CNT_W'(sat_inc(32'(drop_count_reg), CNT_MAX));
        end
    end

    assign drop_count = drop_count_reg;
`endif

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.class_idx   = class_idx_reg;
    assign bus.class_count = class_count_reg;
    assign bus.tie         = tie_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// Directed bench for bnn_vote_accumulator (default parameters, optional BNN_DROP_COUNT_EN).
module tb_bnn_vote_accumulator;

    logic clk;
    logic rst_n;
    logic ena;
    logic clear;
    int   total;
    int   bad;
    int   lat;
    logic seen_ov;
`ifdef BNN_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    bnn_vote_accumulator_if #(.NUM_NEURONS(4), .CNT_W(8), .IDX_W(2)) bus ();

    bnn_vote_accumulator #(
        .NUM_NEURONS (4),
        .CNT_W       (8),
        .WINDOW      (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (clear),
        .bus   (bus)
`ifdef BNN_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One accepted sample; returns #1 after the accepting edge with in_valid low.
    task automatic send(input logic [3:0] bits);
        bus.in_valid    = 1'b1;
        bus.neuron_bits = bits;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.neuron_bits = 4'b0000;
        if (bus.out_valid) seen_ov = 1'b1;
    endtask

    task automatic send_n(input int n, input logic [3:0] bits);
        for (int i = 0; i < n; i++) send(bits);
    endtask

    // Edges until out_valid, bounded; 0 means it never came.
    task automatic wait_decision(output int edges);
        edges = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int exp_lat, input int got_lat,
                                input int idx, input int cnt, input logic t);
        check({tag, "_latency"}, got_lat, exp_lat);
        check({tag, "_idx"},     32'(bus.class_idx), idx);
        check({tag, "_count"},   32'(bus.class_count), cnt);
        check({tag, "_tie"},     32'(bus.tie), 32'(t));
        $display("window %s: idx=%0d count=%0d tie=%0d latency=%0d",
                 tag, bus.class_idx, bus.class_count, bus.tie, got_lat);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        seen_ov         = 1'b0;
        rst_n           = 1'b0;
        ena             = 1'b1;
        clear           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.neuron_bits = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values
        check("rst_in_ready",  32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_idx",       32'(bus.class_idx), 0);
        check("rst_count",     32'(bus.class_count), 0);
        check("rst_tie",       32'(bus.tie), 0);
        check("rst_busy",      32'(bus.busy), 0);

        // 16x 0001
        send_n(16, 4'b0001);
        check("w1_busy",     32'(bus.busy), 1);
        check("w1_in_ready", 32'(bus.in_ready), 0);
        wait_decision(lat);
        check_result("w1", 5, lat, 0, 16, 1'b0);
        @(posedge clk);
        #1;
        check("w1_pulse_width", 32'(bus.out_valid), 0);
        check("w1_ready_back",  32'(bus.in_ready), 1);
        check("w1_idx_held",    32'(bus.class_idx), 0);

        // Alternating 0100 / 1100
        for (int i = 0; i < 8; i++) begin
            send(4'b0100);
            send(4'b1100);
        end
        wait_decision(lat);
        check_result("w2", 5, lat, 2, 16, 1'b0);

        // 8x 0010 + 8x 1000, in_valid held with 1111 for four DECIDE cycles
        send_n(8, 4'b0010);
        send_n(8, 4'b1000);
        bus.in_valid    = 1'b1;
        bus.neuron_bits = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("w3_drop_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid    = 1'b0;
        bus.neuron_bits = 4'b0000;
        wait_decision(lat);
        check_result("w3", 5, (lat == 0) ? 0 : lat + 4, 1, 8, 1'b1);
`ifdef BNN_DROP_COUNT_EN
        check("w3_drop_count", 32'(drop_count), 4);
`endif

        // Dropped 1111 samples must not leak into the next window
        send_n(16, 4'b0010);
        wait_decision(lat);
        check_result("w4", 5, lat, 1, 16, 1'b0);

        // All-zero window
        send_n(16, 4'b0000);
        wait_decision(lat);
        check_result("w5", 5, lat, 0, 0, 1'b1);
        send_n(16, 4'b0010);
        wait_decision(lat);
        check_result("w5b", 5, lat, 1, 16, 1'b0);

        // clear after 10 samples
        send_n(10, 4'b1000);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_idx",      32'(bus.class_idx), 0);
        check("clr_count",    32'(bus.class_count), 0);
        check("clr_tie",      32'(bus.tie), 0);
        check("clr_in_ready", 32'(bus.in_ready), 1);
`ifdef BNN_DROP_COUNT_EN
        check("clr_drop_count", 32'(drop_count), 0);
`endif
        seen_ov = 1'b0;
        send_n(15, 4'b0100);
        check("clr_no_early_decision", 32'(seen_ov), 0);
        check("clr_count_still_0",     32'(bus.class_count), 0);
        send(4'b0100);
        wait_decision(lat);
        check_result("w6", 5, lat, 2, 16, 1'b0);

        // ena low for three cycles mid-scan
        send_n(16, 4'b0101);
        @(posedge clk);
        #1;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("ena_low_no_pulse", 32'(bus.out_valid), 0);
        end
        check("ena_low_busy", 32'(bus.busy), 1);
        ena = 1'b1;
        wait_decision(lat);
        check_result("w7", 8, (lat == 0) ? 0 : lat + 4, 0, 16, 1'b1);

        // rst_n dropped mid-DECIDE
        send_n(16, 4'b0001);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("arst_in_ready",  32'(bus.in_ready), 1);
        check("arst_busy",      32'(bus.busy), 0);
        check("arst_count",     32'(bus.class_count), 0);
        check("arst_tie",       32'(bus.tie), 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_ov = 1'b1;
        end
        check("arst_no_pulse", 32'(seen_ov), 0);
        send_n(16, 4'b1000);
        wait_decision(lat);
        check_result("w8", 5, lat, 3, 16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bnn_vote_accumulator.md
Name: bnn_vote_accumulator

Overview:
- Downstream of the BNN neuron layer. Consumes the per-sample neuron output vector (one bit per neuron) and counts votes per neuron over a fixed window of samples.
- At the end of each window it runs a sequential argmax scan and reports the winning class index, its vote count and a tie flag.
- Turns single-sample binary activations into a stable classification suitable for driving uo_out.

Parameters:
- NUM_NEURONS, 4, number of neuron bits per sample (number of classes).
- CNT_W, 8, width of each per-neuron vote counter; counters saturate at 2^CNT_W-1.
- WINDOW, 16, samples per decision window; legal range 1..2^CNT_W-1.
- IDX_W, $clog2(NUM_NEURONS), width of the class index.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, global enable; when low all state holds (no accept, scan paused).
- in_valid, input, 1, neuron_bits holds a valid sample this cycle.
- neuron_bits, input, NUM_NEURONS, neuron outputs; bit i = neuron i fired.
- clear, input, 1, synchronous restart of the window and outputs.
- in_ready, output, 1, high in ACCUM state (sample is accepted when in_valid & in_ready & ena).
- out_valid, output, 1, one-cycle pulse when a new decision is published.
- class_idx, output, IDX_W, winning neuron index (held until the next decision).
- class_count, output, CNT_W, vote count of the winner (held).
- tie, output, 1, another neuron had an equal maximum count (held).
- busy, output, 1, high in DECIDE state.

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM, all vote counters=0, sample counter=0, scan index=0. Outputs: in_ready=1, out_valid=0, class_idx=0, class_count=0, tie=0, busy=0.
- States:
  - ACCUM: on an accepted sample, each counter i increments iff neuron_bits[i]=1, saturating at all-ones; sample counter increments.
  - When the accepted sample is the WINDOW-th one, next state is DECIDE, with scan index 0, best_idx=0, best_cnt=0, tie_r=0.
- DECIDE: takes one edge per neuron, scanning index k=0..NUM_NEURONS-1.
  - cnt[k] > best_cnt: best_idx=k, best_cnt=cnt[k], tie_r=0.
  - cnt[k] == best_cnt and k>0: tie_r=1.
  - After scanning k=NUM_NEURONS-1, the next edge publishes and returns to ACCUM.
- Publish edge:
  - class_idx=best_idx, class_count=best_cnt, tie=tie_r, out_valid=1 for exactly one cycle.
  - All vote counters and the sample counter clear; in_ready returns to 1.
- Latency: with ena held high, out_valid rises NUM_NEURONS+1 edges after the edge that accepted the final sample (5 edges at default).
- Samples presented while in_ready=0 are dropped. Upstream is combinational and cannot stall, so it holds no data.
- Tie rule: the lowest index wins. tie=1 iff at least one later neuron equals the final maximum. An all-zero window gives idx 0, count 0, tie=1 (for NUM_NEURONS>1).
- ena low: no state, counter or output register changes, except that out_valid is forced to 0 on the next edge. The scan resumes where it stopped.
- clear=1 (sync, only while rst_n high): identical to the reset values on the next edge, regardless of state, and takes priority over a simultaneous accept or publish.
- Saturation is only reachable if WINDOW > 2^CNT_W-1, which is illegal; counters still saturate rather than wrap.
- Reset asserted mid-DECIDE aborts the scan; no out_valid pulse is produced.

Optional Feature:
- Macro BNN_DROP_COUNT_EN.
- When defined: adds output drop_count [CNT_W-1:0]. It increments (saturating) on every cycle with ena & in_valid & !in_ready and is cleared by reset or clear.
- When undefined: the port and its logic are absent; drops are silent.

Decomposition:
- Shared package bnn_pkg: NUM_NEURONS default, CNT_W default, state enum {ACCUM, DECIDE}, and a saturating-increment function.
- Natural sub-module: bnn_argmax_scan, holding the sequential compare, best_idx/best_cnt/tie registers and scan index, with start/done handshake to the accumulator FSM.

Test Plan:
- Reset then 16 samples of 4'b0001 -> out_valid pulse 5 edges after the 16th accept; class_idx=0, class_count=16, tie=0.
- 16 samples alternating 4'b0100/4'b1100 -> class_idx=2, class_count=16, tie=0 (neuron3=8).
- 8x 4'b0010 + 8x 4'b1000 -> class_idx=1, class_count=8, tie=1.
- in_valid held high through DECIDE with 4'b1111 -> those samples are ignored (next window counts start at 0); with BNN_DROP_COUNT_EN, drop_count=4.
- clear pulsed after 10 samples -> next decision only after 16 further accepts; outputs read 0 until then.
- rst_n dropped mid-DECIDE and ena low for 3 cycles mid-scan -> no out_valid on reset; ena-low case publishes 3 cycles later with unchanged result.
